// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, state encodings,
// lane offsets and access-check helpers.
package lsu_pkg;

  // Width codes also used by the decoder
  localparam logic [3:0] MEM_WIDTH_WORD = 4'b0000;
  localparam logic [3:0] MEM_WIDTH_HALF = 4'b0101;
  localparam logic [3:0] MEM_WIDTH_BYTE = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] LANE_OFF_LO = 2'b00;
  localparam logic [1:0] LANE_OFF_HI = 2'b10;

  function automatic logic width_legal(input logic [3:0] width);
    return (width == MEM_WIDTH_WORD) || (width == MEM_WIDTH_HALF) ||
           (width == MEM_WIDTH_BYTE);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] width, input logic [1:0] off);
    return ((width == MEM_WIDTH_HALF) && off[0]) ||
           ((width == MEM_WIDTH_WORD) && (off != LANE_OFF_LO));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed data bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [3:0]  bus_wstrb_out;
  logic [31:0] bus_wdata_out;
  logic        bus_ack_in;
  logic [31:0] bus_rdata_in;

  modport master (
    output bus_req_out, bus_we_out, bus_addr_out, bus_wstrb_out, bus_wdata_out,
    input  bus_ack_in, bus_rdata_in
  );

  modport slave (
    input  bus_req_out, bus_we_out, bus_addr_out, bus_wstrb_out, bus_wdata_out,
    output bus_ack_in, bus_rdata_in
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store-side byte steering and strobes, load-side
// lane selection with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  st_width,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata,
  input  logic [3:0]  ld_width,
  input  logic [1:0]  ld_off,
  input  logic        ld_zext,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = st_data;
    case (st_width)
      MEM_WIDTH_BYTE: begin
        st_wstrb = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_WIDTH_HALF: begin
        st_wstrb = (st_off == LANE_OFF_HI) ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      MEM_WIDTH_WORD: st_wstrb = 4'b1111;
      default:        st_wstrb = 4'b0000;
    endcase
  end

  // Lane selection happens on the raw bus word; extension follows the captured width
  always_comb begin
    ld_shifted = ld_raw >> {ld_off, 3'b000};
    ld_byte    = ld_shifted[7:0];
    ld_half    = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    ld_data    = ld_raw;
    case (ld_width)
      MEM_WIDTH_BYTE: ld_data = ld_zext ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      MEM_WIDTH_HALF: ld_data = ld_zext ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default:        ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one outstanding request/ack bus transaction per load/store.
// Optional bus timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [3:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        ready_out,
  output logic        done_out,
  output logic [31:0] rdata_out,
  output logic        err_out,
  load_store_unit_if.master bus
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] REQ  = ST_REQ;
  localparam logic [1:0] DONE = ST_DONE;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  state;
  logic [3:0]  width_q;
  logic [1:0]  off_q;
  logic        zext_q;
  logic        load_q;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        accept;
  logic        access_bad;
  logic        timed_out;

  assign ready_out  = (state == IDLE);
  assign done_out   = (state == DONE);
  assign accept     = valid_in & (mem_read_in | mem_write_in);
  assign access_bad = (mem_read_in & mem_write_in) | ~width_legal(mem_width_in) |
                      is_misaligned(mem_width_in, addr_in[1:0]);

  lsu_align u_align (
    .st_width (mem_width_in),
    .st_off   (addr_in[1:0]),
    .st_data  (wdata_in),
    .st_wstrb (st_wstrb),
    .st_wdata (st_wdata),
    .ld_width (width_q),
    .ld_off   (off_q),
    .ld_zext  (zext_q),
    .ld_raw   (bus.bus_rdata_in),
    .ld_data  (ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] tmo_cnt;

  // Counts unacknowledged REQ cycles; idle time keeps it cleared for the next request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != REQ) begin
      tmo_cnt <= '0;
    end else if (!bus.bus_ack_in) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timed_out = (state == REQ) && !bus.bus_ack_in &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      width_q           <= MEM_WIDTH_WORD;
      off_q             <= 2'b00;
      zext_q            <= 1'b0;
      load_q            <= 1'b0;
      rdata_out         <= 32'h0;
      err_out           <= 1'b0;
      bus.bus_req_out   <= 1'b0;
      bus.bus_we_out    <= 1'b0;
      bus.bus_addr_out  <= 32'h0;
      bus.bus_wstrb_out <= 4'h0;
      bus.bus_wdata_out <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            width_q <= mem_width_in;
            off_q   <= addr_in[1:0];
            zext_q  <= mem_zero_extend_in;
            load_q  <= mem_read_in;
            if (access_bad) begin
              state     <= DONE;
              err_out   <= 1'b1;
              rdata_out <= 32'h0;
            end else begin
              state             <= REQ;
              err_out           <= 1'b0;
              bus.bus_req_out   <= 1'b1;
              bus.bus_we_out    <= mem_write_in;
              bus.bus_addr_out  <= {addr_in[31:2], 2'b00};
              bus.bus_wstrb_out <= mem_write_in ? st_wstrb : 4'h0;
              bus.bus_wdata_out <= mem_write_in ? st_wdata : 32'h0;
            end
          end
        end
        REQ: begin
          // An ack in the expiry cycle takes priority over the timeout
          if (bus.bus_ack_in) begin
            state           <= DONE;
            bus.bus_req_out <= 1'b0;
            bus.bus_we_out  <= 1'b0;
            rdata_out       <= load_q ? ld_data : 32'h0;
            err_out         <= 1'b0;
          end else if (timed_out) begin
            state           <= DONE;
            bus.bus_req_out <= 1'b0;
            bus.bus_we_out  <= 1'b0;
            rdata_out       <= 32'h0;
            err_out         <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; timeout cases run only
// when LSU_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [3:0]  mem_width_in;
  logic        mem_zero_extend_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        ready_out;
  logic        done_out;
  logic [31:0] rdata_out;
  logic        err_out;

  int compared;
  int mismatched;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .valid_in           (valid_in),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .mem_width_in       (mem_width_in),
    .mem_zero_extend_in (mem_zero_extend_in),
    .addr_in            (addr_in),
    .wdata_in           (wdata_in),
    .ready_out          (ready_out),
    .done_out           (done_out),
    .rdata_out          (rdata_out),
    .err_out            (err_out),
    .bus                (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns 1 time unit after the accept edge
  task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] width,
                               input logic zext, input logic [31:0] addr, input logic [31:0] wdata);
    valid_in           = 1'b1;
    mem_read_in        = rd;
    mem_write_in       = wr;
    mem_width_in       = width;
    mem_zero_extend_in = zext;
    addr_in            = addr;
    wdata_in           = wdata;
    waitCycle();
    valid_in     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
  endtask

  task automatic doStore(input string tag, input logic [3:0] width, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_delay,
                         input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata);
    applyStimulus(1'b0, 1'b1, width, 1'b0, addr, wdata);
    checkOutput({tag, ".req"},   32'(bus_if.bus_req_out), 32'h1);
    checkOutput({tag, ".we"},    32'(bus_if.bus_we_out), 32'h1);
    checkOutput({tag, ".addr"},  bus_if.bus_addr_out, exp_addr);
    checkOutput({tag, ".wstrb"}, 32'(bus_if.bus_wstrb_out), 32'(exp_strb));
    checkOutput({tag, ".wdata"}, bus_if.bus_wdata_out, exp_wdata);
    for (int i = 0; i < ack_delay; i++) waitCycle();
    checkOutput({tag, ".held_req"}, 32'(bus_if.bus_req_out), 32'h1);
    checkOutput({tag, ".no_early_done"}, 32'(done_out), 32'h0);
    bus_if.bus_ack_in = 1'b1;
    waitCycle();
    bus_if.bus_ack_in = 1'b0;
    checkOutput({tag, ".done"}, 32'(done_out), 32'h1);
    checkOutput({tag, ".err"},  32'(err_out), 32'h0);
    checkOutput({tag, ".req_drop"}, 32'(bus_if.bus_req_out), 32'h0);
    waitCycle();
    checkOutput({tag, ".done_pulse"}, 32'(done_out), 32'h0);
    checkOutput({tag, ".ready"}, 32'(ready_out), 32'h1);
  endtask

  task automatic doLoad(input string tag, input logic [3:0] width, input logic zext,
                        input logic [31:0] addr, input logic [31:0] raw, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, width, zext, addr, 32'hFFFF_FFFF);
    checkOutput({tag, ".req"},   32'(bus_if.bus_req_out), 32'h1);
    checkOutput({tag, ".we"},    32'(bus_if.bus_we_out), 32'h0);
    checkOutput({tag, ".wstrb"}, 32'(bus_if.bus_wstrb_out), 32'h0);
    checkOutput({tag, ".addr"},  bus_if.bus_addr_out, {addr[31:2], 2'b00});
    bus_if.bus_ack_in   = 1'b1;
    bus_if.bus_rdata_in = raw;
    waitCycle();
    bus_if.bus_ack_in   = 1'b0;
    bus_if.bus_rdata_in = 32'h0;
    checkOutput({tag, ".done"},  32'(done_out), 32'h1);
    checkOutput({tag, ".err"},   32'(err_out), 32'h0);
    checkOutput({tag, ".rdata"}, rdata_out, exp);
    waitCycle();
    checkOutput({tag, ".ready"}, 32'(ready_out), 32'h1);
  endtask

  task automatic doError(input string tag, input logic rd, input logic wr,
                         input logic [3:0] width, input logic [31:0] addr);
    applyStimulus(rd, wr, width, 1'b0, addr, 32'h1234_5678);
    checkOutput({tag, ".done"},  32'(done_out), 32'h1);
    checkOutput({tag, ".err"},   32'(err_out), 32'h1);
    checkOutput({tag, ".noreq"}, 32'(bus_if.bus_req_out), 32'h0);
    waitCycle();
    checkOutput({tag, ".done_pulse"}, 32'(done_out), 32'h0);
    checkOutput({tag, ".ready"}, 32'(ready_out), 32'h1);
  endtask

  initial begin
    compared            = 0;
    mismatched          = 0;
    reset               = 1'b1;
    valid_in            = 1'b0;
    mem_read_in         = 1'b0;
    mem_write_in        = 1'b0;
    mem_width_in        = 4'b0000;
    mem_zero_extend_in  = 1'b0;
    addr_in             = 32'h0;
    wdata_in            = 32'h0;
    bus_if.bus_ack_in   = 1'b0;
    bus_if.bus_rdata_in = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.ready", 32'(ready_out), 32'h1);
    checkOutput("rst.done",  32'(done_out), 32'h0);
    checkOutput("rst.err",   32'(err_out), 32'h0);
    checkOutput("rst.rdata", rdata_out, 32'h0);
    checkOutput("rst.req",   32'(bus_if.bus_req_out), 32'h0);
    checkOutput("rst.we",    32'(bus_if.bus_we_out), 32'h0);
    checkOutput("rst.addr",  bus_if.bus_addr_out, 32'h0);
    checkOutput("rst.wstrb", 32'(bus_if.bus_wstrb_out), 32'h0);
    checkOutput("rst.wdata", bus_if.bus_wdata_out, 32'h0);
    reset = 1'b0;
    waitCycle();

    // valid without read/write must be ignored
    valid_in = 1'b1;
    waitCycle();
    valid_in = 1'b0;
    checkOutput("nop.ready", 32'(ready_out), 32'h1);
    checkOutput("nop.req",   32'(bus_if.bus_req_out), 32'h0);

    doStore("sb", 4'b1010, 32'h0000_1003, 32'hAABB_CCDD, 1, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD);
    doStore("sb0", 4'b1010, 32'h0000_1000, 32'h0000_0042, 0, 32'h0000_1000, 4'b0001, 32'h4242_4242);
    doStore("sh", 4'b0101, 32'h0000_5002, 32'h1234_ABCD, 0, 32'h0000_5000, 4'b1100, 32'hABCD_ABCD);
    doStore("sw", 4'b0000, 32'h0000_5004, 32'hCAFE_F00D, 2, 32'h0000_5004, 4'b1111, 32'hCAFE_F00D);

    doLoad("lb",  4'b1010, 1'b0, 32'h0000_2001, 32'h1234_80FF, 32'hFFFF_FF80);
    doLoad("lbu", 4'b1010, 1'b1, 32'h0000_2001, 32'h1234_80FF, 32'h0000_0080);
    doLoad("lb3", 4'b1010, 1'b0, 32'h0000_2003, 32'h7F34_80FF, 32'h0000_007F);
    doLoad("lhu", 4'b0101, 1'b1, 32'h0000_2002, 32'h9ABC_0000, 32'h0000_9ABC);
    doLoad("lh",  4'b0101, 1'b0, 32'h0000_2002, 32'h9ABC_0000, 32'hFFFF_9ABC);
    doLoad("lhlo", 4'b0101, 1'b0, 32'h0000_2000, 32'h9ABC_8001, 32'hFFFF_8001);
    doLoad("lw",  4'b0000, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    doError("lw_mis",  1'b1, 1'b0, 4'b0000, 32'h0000_3002);
    doError("lw_ill",  1'b1, 1'b0, 4'b0011, 32'h0000_3000);
    doError("lh_mis",  1'b1, 1'b0, 4'b0101, 32'h0000_3001);
    doError("rw_both", 1'b1, 1'b1, 4'b0000, 32'h0000_3000);

    // Reset during REQ, followed by a stray ack in IDLE
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0000_6000, 32'h0);
    checkOutput("rreq.req", 32'(bus_if.bus_req_out), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rreq.req_drop", 32'(bus_if.bus_req_out), 32'h0);
    checkOutput("rreq.ready",    32'(ready_out), 32'h1);
    #2;
    reset = 1'b0;
    waitCycle();
    bus_if.bus_ack_in   = 1'b1;
    bus_if.bus_rdata_in = 32'h5555_AAAA;
    waitCycle();
    bus_if.bus_ack_in   = 1'b0;
    checkOutput("rreq.no_done",  32'(done_out), 32'h0);
    checkOutput("rreq.ready2",   32'(ready_out), 32'h1);
    checkOutput("rreq.req_idle", 32'(bus_if.bus_req_out), 32'h0);
    waitCycle();
    checkOutput("rreq.no_done2", 32'(done_out), 32'h0);

`ifdef LSU_TIMEOUT_EN
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0000_7000, 32'h0);
    checkOutput("tmo.req1", 32'(bus_if.bus_req_out), 32'h1);
    for (int i = 2; i <= 4; i++) begin
      waitCycle();
      checkOutput($sformatf("tmo.req%0d", i), 32'(bus_if.bus_req_out), 32'h1);
    end
    waitCycle();
    checkOutput("tmo.done",  32'(done_out), 32'h1);
    checkOutput("tmo.err",   32'(err_out), 32'h1);
    checkOutput("tmo.rdata", rdata_out, 32'h0);
    checkOutput("tmo.req_drop", 32'(bus_if.bus_req_out), 32'h0);
    waitCycle();

    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0000_7004, 32'h0);
    repeat (3) waitCycle();
    checkOutput("tmo_ack.req4", 32'(bus_if.bus_req_out), 32'h1);
    bus_if.bus_ack_in   = 1'b1;
    bus_if.bus_rdata_in = 32'h0BAD_F00D;
    waitCycle();
    bus_if.bus_ack_in   = 1'b0;
    checkOutput("tmo_ack.done",  32'(done_out), 32'h1);
    checkOutput("tmo_ack.err",   32'(err_out), 32'h0);
    checkOutput("tmo_ack.rdata", rdata_out, 32'h0BAD_F00D);
    waitCycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Executes the memory half of a decoded load/store instruction. It consumes the decoder's memory controls (mem_read, mem_write, mem_width, mem_zero_extend) plus the ALU-computed address and rs2 data. It runs one single-outstanding request/acknowledge transaction on a 32-bit word-addressed data bus, with byte strobes. Load data is returned sign- or zero-extended to the writeback stage, with a one-cycle done pulse.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait for bus_ack_in before aborting; used only when LSU_TIMEOUT_EN is defined; must be at least 1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
valid_in  in  1  request strobe from pipeline; sampled only when ready_out=1
mem_read_in  in  1  load request
mem_write_in  in  1  store request
mem_width_in  in  4  0000=word, 0101=half, 1010=byte; any other value is illegal
mem_zero_extend_in  in  1  1=zero-extend load, 0=sign-extend; ignored for word and for stores
addr_in  in  32  byte address (ALU result)
wdata_in  in  32  store data (rs2), low-order bits significant
ready_out  out  1  1 when idle and able to accept a request
done_out  out  1  one-cycle completion pulse
rdata_out  out  32  extended load data; valid while done_out=1
err_out  out  1  completion with error (misaligned, illegal, timeout); valid while done_out=1
bus_req_out  out  1  bus request, held until acknowledged
bus_we_out  out  1  1=write
bus_addr_out  out  32  word-aligned address, {addr[31:2],2'b00}
bus_wstrb_out  out  4  byte-lane enables; 0000 on reads
bus_wdata_out  out  32  lane-replicated store data
bus_ack_in  in  1  bus acknowledge; read data valid in the same cycle
bus_rdata_in  in  32  bus read data

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State=IDLE.
  - bus_req_out, bus_we_out, done_out, err_out = 0.
  - bus_addr_out, bus_wstrb_out, bus_wdata_out, rdata_out = 0.
  - ready_out = 1 (it is the IDLE decode).
- Reset mid-transaction drops bus_req_out immediately. A late bus_ack_in that then arrives in IDLE is ignored.
- FSM states: IDLE, REQ, DONE.
  - IDLE: ready_out=1. Acceptance is valid_in & (mem_read_in | mem_write_in). valid_in with neither control bit set is ignored.
  - On an accepted request, the unit checks the access:
    - Illegal if mem_read_in & mem_write_in are both set, or the width code is not one of the three legal values.
    - Misaligned if half with addr[0]=1, or word with addr[1:0]≠00.
    - An illegal or misaligned request goes to DONE with err_out=1 and issues no bus transaction.
    - Otherwise the unit registers all bus outputs and goes to REQ.
  - REQ: bus_req_out=1, and all bus outputs are held stable. On bus_ack_in=1:
    - Load: capture the lane-selected, extended bus_rdata_in into rdata_out.
    - Store: rdata_out=0.
    - Then go to DONE.
  - DONE: done_out=1 for exactly one cycle, then IDLE. bus_req_out deasserts on entry to DONE.
- Latency:
  - Accept at edge N. bus_req_out is high from N.
  - Earliest ack is in the cycle after N.
  - done_out asserts the cycle after the ack. Minimum accept-to-done is 2 cycles.
  - An error completion's done_out follows accept by 1 cycle.
  - Back-to-back requests: a new accept is possible in the cycle after done_out.
- Store lanes (o = addr[1:0]):
  - byte: wstrb = 0001<<o; wdata = {4{wdata_in[7:0]}}.
  - half: wstrb = 0011 (o=00) or 1100 (o=10); wdata = {2{wdata_in[15:0]}}.
  - word: wstrb = 1111; wdata = wdata_in.
- Load extraction:
  - byte: bits [8o+7:8o].
  - half: bits [15:0] or [31:16].
  - The selected field is extended to 32 bits by mem_zero_extend_in, captured at accept.
  - word: passed through unchanged.
- rdata_out and err_out keep their last values outside DONE. Consumers sample them only with done_out.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - An 8..32-bit cycle counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the unit drops bus_req_out, goes to DONE with err_out=1 and rdata_out=0.
  - An ack in the same cycle as expiry wins: normal completion.
- Undefined: no counter exists; REQ waits indefinitely.

Decomposition:
- Package lsu_pkg holds:
  - MEM_WIDTH_WORD/HALF/BYTE codes, shared with the decoder.
  - The state enum {IDLE,REQ,DONE}.
  - Lane-offset constants.
- Natural sub-module: lsu_align. It is combinational and does store lane steering plus wstrb generation, load lane selection, and sign/zero extension. It is instantiated once, with two functional halves.

Test Plan:
- SB addr=0x1003, wdata=0xAABBCCDD, ack after 2 cycles -> bus_addr=0x1000, wstrb=1000, wdata=0xDDDDDDDD, we=1; done 1 cycle after ack, err=0.
- LB addr=0x2001, bus_rdata=0x1234_80FF, zero_ext=0 -> rdata_out=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- LHU addr=0x2002, bus_rdata=0x9ABC_0000 -> rdata_out=0x00009ABC. LH with the same stimulus -> 0xFFFF9ABC.
- LW addr=0x3002 -> no bus_req; done_out 1 cycle after accept with err_out=1. The same check with width=0011 (illegal) also gives err_out=1.
- Assert reset while in REQ, then pulse bus_ack_in -> bus_req_out drops immediately; after reset, ready_out=1 and done_out stays 0.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives -> bus_req high for 4 cycles, then done_out=1 and err_out=1. Ack on cycle 4 -> normal completion, err_out=0.
